exe_stage: RTL and testbench

- Execute stage of the 5-stage LoongArch pipeline.
- Sits between the decode stage and the memory stage.
- Registers the 158-bit decode bundle and computes the ALU, multiply and iterative divide results.
- Issues the data-SRAM request, forwards a 71-bit bundle to MEM, and exports forwarding/hazard info back to decode.

---
 rtl/exe_stage_pkg.sv | 74 +++++++
 rtl/exe_stage_if.sv | 32 +++
 rtl/exe_stage_div_iter.sv | 82 ++++++++
 rtl/exe_stage.sv | 115 +++++++++++
 tb/tb_exe_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared types and constants for the execute stage.
// Bundle layouts, ALU op indices and divider states.
package exe_stage_pkg;

    localparam int EXE_W      = 158;
    localparam int MEM_W      = 71;
    localparam int FWD_W      = 39;
    localparam int ALU_OP_W   = 19;
    localparam int DIV_CYCLES = 32;

    localparam int EXE_PC_LSB     = 126;
    localparam int EXE_RF_WE      = 125;
    localparam int EXE_WADDR_LSB  = 120;
    localparam int EXE_RKD_LSB    = 88;
    localparam int EXE_FROM_MEM   = 87;
    localparam int EXE_MEM_WE_LSB = 83;
    localparam int EXE_OP_LSB     = 64;
    localparam int EXE_SRC1_LSB   = 32;
    localparam int EXE_SRC2_LSB   = 0;

    localparam int OP_ADD     = 0;
    localparam int OP_SUB     = 1;
    localparam int OP_SLT     = 2;
    localparam int OP_SLTU    = 3;
    localparam int OP_AND     = 4;
    localparam int OP_NOR     = 5;
    localparam int OP_OR      = 6;
    localparam int OP_XOR     = 7;
    localparam int OP_SLL     = 8;
    localparam int OP_SRL     = 9;
    localparam int OP_SRA     = 10;
    localparam int OP_LU12I   = 11;
    localparam int OP_MUL     = 12;
    localparam int OP_MULH    = 13;
    localparam int OP_MULHU   = 14;
    localparam int OP_DIV     = 15;
    localparam int OP_DIVU    = 16;
    localparam int OP_MOD     = 17;
    localparam int OP_MODU    = 18;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0]         pc;
        logic                rf_we;
        logic [4:0]          rf_waddr;
        logic [31:0]         rkd_value;
        logic                res_from_mem;
        logic [3:0]          mem_we;
        logic [ALU_OP_W-1:0] alu_op;
        logic [31:0]         alu_src1;
        logic [31:0]         alu_src2;
    } exe_bundle_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        res_from_mem;
        logic [31:0] result;
    } mem_bundle_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic        is_load;
        logic [31:0] data;
    } fwd_t;

endpackage

// File: rtl/exe_stage_if.sv
// Execute-stage boundary: decode input, MEM output,
// data SRAM request and forwarding back to decode.
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic             EXE_signal_valid;
    logic [EXE_W-1:0] EXE_signal;
    logic             MEM_allowin;
    logic             EXE_allowin;
    logic             MEM_signal_valid;
    logic [MEM_W-1:0] MEM_signal;
    logic             data_sram_en;
    logic [3:0]       data_sram_we;
    logic [31:0]      data_sram_addr;
    logic [31:0]      data_sram_wdata;
    logic [FWD_W-1:0] EXE_fwd;

    modport master (
        output EXE_signal_valid, EXE_signal, MEM_allowin,
        input  EXE_allowin, MEM_signal_valid, MEM_signal,
        input  data_sram_en, data_sram_we, data_sram_addr,
        input  data_sram_wdata, EXE_fwd
    );

    modport slave (
        input  EXE_signal_valid, EXE_signal, MEM_allowin,
        output EXE_allowin, MEM_signal_valid, MEM_signal,
        output data_sram_en, data_sram_we, data_sram_addr,
        output data_sram_wdata, EXE_fwd
    );

endinterface

// File: rtl/exe_stage_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle.
// Works on magnitudes; signs are re-applied in DONE.
module div_iter
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q, quo_q, dsr_q;
    logic        neg_q, neg_r;

    logic [31:0] dvd_mag, dsr_mag;
    logic [32:0] shifted, diff;
    logic [31:0] rem_nx, quo_nx;
    logic        last_step;

    assign dvd_mag = (signed_op & dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign dsr_mag = (signed_op & divisor[31]) ? (~divisor + 32'd1) : divisor;

    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dsr_q};
    assign rem_nx  = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_nx  = {quo_q[30:0], ~diff[32]};

    assign last_step = (cnt_q == 6'(DIV_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= DIV_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (start)     state_d = DIV_BUSY;
            DIV_BUSY: if (last_step) state_d = DIV_DONE;
            DIV_DONE: if (ack)       state_d = DIV_IDLE;
            default:                 state_d = DIV_IDLE;
        endcase
    end

    // Operand latch on start, one shift-subtract per BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state_q == DIV_IDLE && start) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= dvd_mag;
            dsr_q <= dsr_mag;
            neg_q <= signed_op & (dividend[31] ^ divisor[31]);
            neg_r <= signed_op & dividend[31];
        end else if (state_q == DIV_BUSY) begin
            cnt_q <= cnt_q + 6'd1;
            rem_q <= rem_nx;
            quo_q <= quo_nx;
        end
    end

    assign done      = (state_q == DIV_DONE);
    assign quotient  = neg_q ? (~quo_q + 32'd1) : quo_q;
    assign remainder = neg_r ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: stage register, ALU, multiplier, divider,
// data SRAM request and forwarding info for decode.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    exe_stage_if.slave bus
);

    logic        exe_valid;
    exe_bundle_t bq;

    logic        is_div, is_mem, readygo, allowin;
    logic        div_done, div_signed, sram_go;
    logic [31:0] div_q, div_r;
    logic [31:0] src1, src2, result;
    logic [4:0]  sh;
    logic        mul_sext;
    logic signed [32:0] ma, mb;
    logic signed [63:0] prod;

    assign src1 = bq.alu_src1;
    assign src2 = bq.alu_src2;
    assign sh   = src2[4:0];

    assign is_div  = |bq.alu_op[OP_MODU:OP_DIV];
    assign is_mem  = bq.res_from_mem | (|bq.mem_we);
    assign readygo = ~is_div | div_done;
    assign allowin = ~exe_valid | (readygo & bus.MEM_allowin);

    // Stage register; bundle only loads on an accepted valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_valid <= 1'b0;
            bq        <= '0;
        end else if (allowin) begin
            exe_valid <= bus.EXE_signal_valid;
            if (bus.EXE_signal_valid) bq <= bus.EXE_signal;
        end
    end

    assign mul_sext = bq.alu_op[OP_MULH];
    assign ma   = {mul_sext & src1[31], src1};
    assign mb   = {mul_sext & src2[31], src2};
    assign prod = 64'(ma) * 64'(mb);

    assign div_signed = bq.alu_op[OP_DIV] | bq.alu_op[OP_MOD];

    div_iter u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (exe_valid & is_div),
        .signed_op (div_signed),
        .dividend  (src1),
        .divisor   (src2),
        .ack       (bus.MEM_allowin),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // One-hot result select; an empty op yields zero.
    always_comb begin
        result = '0;
        unique case (1'b1)
            bq.alu_op[OP_ADD]:   result = src1 + src2;
            bq.alu_op[OP_SUB]:   result = src1 - src2;
            bq.alu_op[OP_SLT]:   result = {31'd0, $signed(src1) < $signed(src2)};
            bq.alu_op[OP_SLTU]:  result = {31'd0, src1 < src2};
            bq.alu_op[OP_AND]:   result = src1 & src2;
            bq.alu_op[OP_NOR]:   result = ~(src1 | src2);
            bq.alu_op[OP_OR]:    result = src1 | src2;
            bq.alu_op[OP_XOR]:   result = src1 ^ src2;
            bq.alu_op[OP_SLL]:   result = src1 << sh;
            bq.alu_op[OP_SRL]:   result = src1 >> sh;
            bq.alu_op[OP_SRA]:   result = 32'($signed(src1) >>> sh);
            bq.alu_op[OP_LU12I]: result = src2;
            bq.alu_op[OP_MUL]:   result = prod[31:0];
            bq.alu_op[OP_MULH]:  result = prod[63:32];
            bq.alu_op[OP_MULHU]: result = prod[63:32];
            bq.alu_op[OP_DIV]:   result = div_q;
            bq.alu_op[OP_DIVU]:  result = div_q;
            bq.alu_op[OP_MOD]:   result = div_r;
            bq.alu_op[OP_MODU]:  result = div_r;
            default:             result = '0;
        endcase
    end

    mem_bundle_t mo;
    fwd_t        fo;

    assign mo.pc           = bq.pc;
    assign mo.rf_we        = bq.rf_we;
    assign mo.rf_waddr     = bq.rf_waddr;
    assign mo.res_from_mem = bq.res_from_mem;
    assign mo.result       = result;

    assign fo.we      = exe_valid & bq.rf_we;
    assign fo.addr    = bq.rf_waddr;
    assign fo.is_load = exe_valid & (bq.res_from_mem | (is_div & ~div_done));
    assign fo.data    = result;

    assign sram_go = exe_valid & readygo & bus.MEM_allowin & is_mem;

    assign bus.EXE_allowin      = allowin;
    assign bus.MEM_signal_valid = exe_valid & readygo;
    assign bus.MEM_signal       = mo;
    assign bus.data_sram_en     = sram_go;
    assign bus.data_sram_we     = sram_go ? bq.mem_we : 4'd0;
    assign bus.data_sram_addr   = result;
    assign bus.data_sram_wdata  = bq.rkd_value;
    assign bus.EXE_fwd          = fo;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table,
// multi-cycle sequences and randomized ops vs a reference model.
module tb_exe_stage;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    exe_stage_if bus();

    exe_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [157:0] mk(input logic [31:0] pc,
        input logic we, input logic [4:0] wa, input logic [31:0] rkd,
        input logic rfm, input logic [3:0] mwe, input int op,
        input logic [31:0] s1, input logic [31:0] s2);
        logic [18:0] oh;
        oh = '0;
        if (op >= 0) oh[op] = 1'b1;
        return {pc, we, wa, rkd, rfm, mwe, oh, s1, s2};
    endfunction

    function automatic int lat_of(input int op);
        return (op >= 15 && op <= 18) ? 33 : 0;
    endfunction

    // Reference: plain arithmetic on the architectural meaning of each op.
    function automatic logic [31:0] ref_alu(input int op,
        input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (ua < ub) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: begin
                sp = sa >>> b[4:0];
                t = sp;
                return t[31:0];
            end
            11: return b;
            12: begin up = ua * ub; t = up; return t[31:0]; end
            13: begin sp = sa * sb; t = sp; return t[63:32]; end
            14: begin up = ua * ub; t = up; return t[63:32]; end
            15: begin sp = sa / sb; t = sp; return t[31:0]; end
            16: return a / b;
            17: begin sp = sa % sb; t = sp; return t[31:0]; end
            18: return a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Issue one instruction with MEM open; wait for it to reach MEM.
    task automatic run_op(input int op, input logic [31:0] s1,
        input logic [31:0] s2, input logic [4:0] wa,
        output logic [70:0] ms, output int lat,
        output logic al0, output logic [38:0] fwd0,
        output logic [38:0] fwd);
        bus.EXE_signal = mk(32'h1c00_0000 + {27'd0, wa}, 1'b1, wa,
                            32'd0, 1'b0, 4'd0, op, s1, s2);
        bus.EXE_signal_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.EXE_signal_valid = 1'b0;
        @(negedge clk);
        al0  = bus.EXE_allowin;
        fwd0 = bus.EXE_fwd;
        lat  = 0;
        while (!bus.MEM_signal_valid && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        ms  = bus.MEM_signal;
        fwd = bus.EXE_fwd;
        @(posedge clk);
        #1;
    endtask

    vec_t        vt[$];
    logic [70:0] ms;
    logic [38:0] fwd0, fwd;
    logic        al0;
    int          lat;

    initial begin
        bus.EXE_signal_valid = 1'b0;
        bus.EXE_signal       = '0;
        bus.MEM_allowin      = 1'b1;
        reset                = 1'b1;

        #12;
        chk("rst_mem_valid", {63'd0, bus.MEM_signal_valid}, 64'd0);
        chk("rst_sram_en",   {63'd0, bus.data_sram_en}, 64'd0);
        chk("rst_sram_we",   {60'd0, bus.data_sram_we}, 64'd0);
        chk("rst_fwd",       {25'd0, bus.EXE_fwd}, 64'd0);
        chk("rst_allowin",   {63'd0, bus.EXE_allowin}, 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        vt.push_back('{0,  32'd5,         32'hFFFF_FFFF, 32'd4});
        vt.push_back('{1,  32'd3,         32'd5,         32'hFFFF_FFFE});
        vt.push_back('{2,  32'hFFFF_FFFF, 32'd1,         32'd1});
        vt.push_back('{3,  32'hFFFF_FFFF, 32'd1,         32'd0});
        vt.push_back('{4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
        vt.push_back('{5,  32'd0,         32'd0,         32'hFFFF_FFFF});
        vt.push_back('{6,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF});
        vt.push_back('{7,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555});
        vt.push_back('{8,  32'd1,         32'd31,        32'h8000_0000});
        vt.push_back('{9,  32'h8000_0000, 32'd4,         32'h0800_0000});
        vt.push_back('{10, 32'h8000_0000, 32'd4,         32'hF800_0000});
        vt.push_back('{11, 32'd0,         32'h1234_5000, 32'h1234_5000});
        vt.push_back('{12, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE});
        vt.push_back('{13, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF});
        vt.push_back('{14, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001});
        vt.push_back('{-1, 32'd7,         32'd9,         32'd0});
        vt.push_back('{15, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        vt.push_back('{17, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        vt.push_back('{16, 32'd100,       32'd7,         32'd14});
        vt.push_back('{18, 32'd100,       32'd7,         32'd2});
        vt.push_back('{15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vt.push_back('{17, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});

        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].s1, vt[i].s2, 5'd3, ms, lat, al0, fwd0, fwd);
            chk($sformatf("vec%0d_result", i), {32'd0, ms[31:0]}, {32'd0, vt[i].exp});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(lat_of(vt[i].op)));
            chk($sformatf("vec%0d_allowin0", i), {63'd0, al0},
                {63'd0, (lat_of(vt[i].op) == 0)});
        end

        // Divider not done yet: decode sees a load-like stall.
        run_op(16, 32'd10, 32'd3, 5'd9, ms, lat, al0, fwd0, fwd);
        chk("div_busy_fwd_stall", {62'd0, fwd0[38], fwd0[32]}, 64'd3);
        chk("div_done_fwd", {25'd0, fwd}, {25'd0, 1'b1, 5'd9, 1'b0, 32'd3});

        // Divide by zero must still finish on time.
        run_op(15, 32'd5, 32'd0, 5'd1, ms, lat, al0, fwd0, fwd);
        chk("div0_latency", 64'(lat), 64'd33);

        // Store held by MEM backpressure: exactly one write pulse.
        begin
            logic        st_en, st_al;
            int          pulses;
            logic [31:0] addr, wdata;
            logic [3:0]  we;
            st_en = 1'b0; st_al = 1'b0; pulses = 0;
            addr = '0; wdata = '0; we = '0;
            bus.MEM_allowin = 1'b0;
            bus.EXE_signal = mk(32'h1c00_0100, 1'b0, 5'd0, 32'h0000_ABCD,
                                1'b0, 4'hF, 0, 32'h0000_1000, 32'd0);
            bus.EXE_signal_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.EXE_signal_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                st_en |= bus.data_sram_en;
                st_al |= bus.EXE_allowin;
                @(posedge clk);
                #1;
            end
            bus.MEM_allowin = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (bus.data_sram_en) begin
                    pulses++;
                    addr  = bus.data_sram_addr;
                    wdata = bus.data_sram_wdata;
                    we    = bus.data_sram_we;
                end
                @(posedge clk);
                #1;
            end
            chk("st_stall_en", {63'd0, st_en}, 64'd0);
            chk("st_stall_allowin", {63'd0, st_al}, 64'd0);
            chk("st_pulses", 64'(pulses), 64'd1);
            chk("st_addr", {32'd0, addr}, 64'h1000);
            chk("st_wdata", {32'd0, wdata}, 64'hABCD);
            chk("st_we", {60'd0, we}, 64'hF);
        end

        // Reset in the middle of a divide.
        bus.EXE_signal = mk(32'h1c00_0200, 1'b1, 5'd4, 32'd0, 1'b0,
                            4'd0, 15, 32'hFFFF_FFF9, 32'd2);
        bus.EXE_signal_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.EXE_signal_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("busy_allowin", {63'd0, bus.EXE_allowin}, 64'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_mem_valid", {63'd0, bus.MEM_signal_valid}, 64'd0);
        chk("midrst_allowin", {63'd0, bus.EXE_allowin}, 64'd1);
        chk("midrst_fwd", {25'd0, bus.EXE_fwd}, 64'd0);
        chk("midrst_sram_en", {63'd0, bus.data_sram_en}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_op(16, 32'd100, 32'd7, 5'd2, ms, lat, al0, fwd0, fwd);
        chk("postrst_latency", 64'(lat), 64'd33);
        chk("postrst_result", {32'd0, ms[31:0]}, 64'd14);

        // Randomized ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            int          op;
            logic [31:0] a, b;
            logic [4:0]  wa;
            op = int'($urandom_range(0, 19)) - 1;
            if (op >= 15 && n % 3 != 0) op = int'($urandom_range(0, 14));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (op >= 15 && b == 32'd0) b = 32'd3;
            wa = 5'($urandom);
            run_op(op, a, b, wa, ms, lat, al0, fwd0, fwd);
            chk($sformatf("rnd%0d_op%0d_result", n, op), {32'd0, ms[31:0]},
                {32'd0, ref_alu(op, a, b)});
            chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(lat_of(op)));
            chk($sformatf("rnd%0d_mem_hdr", n), {25'd0, ms[70:32]},
                {25'd0, 32'h1c00_0000 + {27'd0, wa}, 1'b1, wa, 1'b0});
            chk($sformatf("rnd%0d_fwd", n), {25'd0, fwd},
                {25'd0, 1'b1, wa, 1'b0, ref_alu(op, a, b)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
